// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port data RAM arbiter.
// FSM state encoding and requester port indices.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam int P_CPU = 0;
  localparam int P_LDR = 1;

endpackage

// File: rtl/ram_arb_rsp.sv
// Per-port read response register for the RAM arbiter.
// Captures RAM data on a granted read; rvalid pulses the next cycle.
module ram_arb_rsp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_gnt,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_ramdata,
  output logic                  o_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic rd;

  assign rd = i_gnt & ~i_we;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
    end else begin
      o_rvalid <= rd;
      if (rd) o_rdata <= i_ramdata;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between CPU and loader.
// Supports bounded burst locking; read data is returned one cycle later.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_we0,
  input  logic                  i_we1,
  input  logic                  i_lock0,
  input  logic                  i_lock1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_gnt0,
  output logic                  o_gnt1,
  output logic                  o_rvalid0,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ramdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  state_t        state;
  logic          last;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          gnt0;
  logic          gnt1;
  logic          gnt_any;
  logic          lock_g;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      unique case (state)
        ST_IDLE: begin
          if (i_req0 && i_req1) begin
            gnt0 = last;
            gnt1 = ~last;
          end else begin
            gnt0 = i_req0;
            gnt1 = i_req1;
          end
        end
        ST_OWN0: gnt0 = i_req0;
        ST_OWN1: gnt1 = i_req1;
        default: ;
      endcase
    end
  end

  assign gnt_any = gnt0 | gnt1;
  assign lock_g  = gnt1 ? i_lock1 : i_lock0;
  assign cnt_nxt = cnt + CW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            last <= gnt1;
            if (lock_g && MAX_BURST > 1) begin
              state <= gnt1 ? ST_OWN1 : ST_OWN0;
              cnt   <= CW'(1);
            end
          end
        end
        default: begin
          if (!gnt_any) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            last <= gnt1;
            // Release on unlock or when the burst cap is reached.
            if (!lock_g || cnt_nxt == CW'(MAX_BURST)) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
      endcase
    end
  end

  assign o_gnt0     = gnt0;
  assign o_gnt1     = gnt1;
  assign o_ram_addr = gnt1 ? i_addr1 : i_addr0;
  assign o_ram_data = gnt1 ? i_wdata1 : i_wdata0;
  assign o_ram_we   = (gnt0 & i_we0) | (gnt1 & i_we1);

  ram_arb_rsp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rsp0 (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_gnt    (gnt0),
    .i_we     (i_we0),
    .i_ramdata(i_ramdata),
    .o_rvalid (o_rvalid0),
    .o_rdata  (o_rdata0)
  );

  ram_arb_rsp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rsp1 (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_gnt    (gnt1),
    .i_we     (i_we1),
    .i_ramdata(i_ramdata),
    .o_rvalid (o_rvalid1),
    .o_rdata  (o_rdata1)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural RAM and arbitration model.
// Directed scenarios followed by randomized two-port traffic.
module tb_ram_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req [2];
  logic        we  [2];
  logic        lk  [2];
  logic [7:0]  addr [2];
  logic [31:0] wdat [2];
  logic        gnt0, gnt1, rv0, rv1, ram_we;
  logic [31:0] rd0, rd1, ram_data, ramdata;
  logic [7:0]  ram_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MAX_BURST(MAXB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req[0]), .i_req1(req[1]),
    .i_we0(we[0]), .i_we1(we[1]),
    .i_lock0(lk[0]), .i_lock1(lk[1]),
    .i_addr0(addr[0]), .i_addr1(addr[1]),
    .i_wdata0(wdat[0]), .i_wdata1(wdat[1]),
    .o_gnt0(gnt0), .o_gnt1(gnt1),
    .o_rvalid0(rv0), .o_rvalid1(rv1),
    .o_rdata0(rd0), .o_rdata1(rd1),
    .o_ram_addr(ram_addr), .o_ram_data(ram_data),
    .o_ram_we(ram_we), .i_ramdata(ramdata)
  );

  function automatic logic [31:0] init_val(int a);
    if (a == 16) return 32'h12345678;
    return (32'(a) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  // Environment RAM: synchronous write, combinational read.
  logic [31:0] mem [256];
  bit          wrt [256];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_data;
      wrt[ram_addr] <= 1'b1;
    end
  end
  assign ramdata = wrt[ram_addr] ? mem[ram_addr] : init_val(int'(ram_addr));

  logic [31:0] ref_mem [256];
  logic [31:0] q [2][$];
  logic [31:0] last_rd [2] = '{32'd0, 32'd0};
  int m_owner = -1;
  int m_run = 0;
  int m_last = 1;
  int last_g;
  int gseq [$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r,
                      input logic rq0, input logic we0, input logic lk0,
                      input logic [7:0] a0, input logic [31:0] d0,
                      input logic rq1, input logic we1, input logic lk1,
                      input logic [7:0] a1, input logic [31:0] d1);
    int g;
    @(negedge clk);
    rst = r;
    req[0] = rq0; we[0] = we0; lk[0] = lk0; addr[0] = a0; wdat[0] = d0;
    req[1] = rq1; we[1] = we1; lk[1] = lk1; addr[1] = a1; wdat[1] = d1;
    #1;
    g = -1;
    if (!r) begin
      if (m_owner >= 0) begin
        if (req[m_owner]) g = m_owner;
      end else if (rq0 && rq1) g = 1 - m_last;
      else if (rq0) g = 0;
      else if (rq1) g = 1;
    end
    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    chk("ram_we", 32'(ram_we), (g >= 0) ? 32'(we[g]) : 32'd0);
    if (g >= 0) begin
      chk("ram_addr", 32'(ram_addr), 32'(addr[g]));
      if (we[g]) begin
        chk("ram_data", ram_data, wdat[g]);
        ref_mem[addr[g]] = wdat[g];
      end else begin
        q[g].push_back(ref_mem[addr[g]]);
      end
    end
    if (r) begin
      m_owner = -1; m_last = 1; m_run = 0;
    end else if (m_owner < 0) begin
      if (g >= 0) begin
        m_last = g;
        if (lk[g] && MAXB > 1) begin m_owner = g; m_run = 1; end
      end
    end else if (g < 0) begin
      m_owner = -1;
    end else begin
      m_last = g;
      m_run++;
      if (!lk[g] || m_run == MAXB) m_owner = -1;
    end
    last_g = g;
    gseq.push_back(g);
  endtask

  task automatic idle(input logic r);
    step(r, 0, 0, 0, 8'h0, 32'h0, 0, 0, 0, 8'h0, 32'h0);
  endtask

  task automatic check_seq(string nm, int exp [$]);
    chk({nm, "_len"}, 32'(gseq.size()), 32'(exp.size()));
    foreach (exp[i])
      if (i < gseq.size()) chk(nm, 32'(gseq[i]), 32'(exp[i]));
  endtask

  // Monitor: response expected at the edge ending each granted read cycle.
  logic mr;
  always @(posedge clk) begin
    mr = rst;
    #2;
    if (mr) begin
      last_rd[0] = 32'd0;
      last_rd[1] = 32'd0;
      chk("rst_rvalid0", 32'(rv0), 32'd0);
      chk("rst_rvalid1", 32'(rv1), 32'd0);
      chk("rst_rdata0", rd0, 32'd0);
      chk("rst_rdata1", rd1, 32'd0);
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (q[p].size() > 0) begin
          last_rd[p] = q[p].pop_front();
          chk(p == 0 ? "rvalid0" : "rvalid1", 32'(p == 0 ? rv0 : rv1), 32'd1);
        end else begin
          chk(p == 0 ? "idle_rvalid0" : "idle_rvalid1",
              32'(p == 0 ? rv0 : rv1), 32'd0);
        end
        chk(p == 0 ? "rdata0" : "rdata1", p == 0 ? rd0 : rd1, last_rd[p]);
      end
    end
  end

  initial begin
    int k;
    bit done0;
    logic        p_rq [2];
    logic        p_we [2];
    logic [7:0]  p_a  [2];
    logic [31:0] p_d  [2];
    logic        p_lk [2];
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; we[p] = 0; lk[p] = 0; addr[p] = 0; wdat[p] = 0;
      p_rq[p] = 0; p_we[p] = 0; p_a[p] = 0; p_d[p] = 0; p_lk[p] = 0;
    end

    // Write attempt during reset must not reach the RAM
    step(1, 1, 1, 0, 8'h05, 32'h0000DEAD, 0, 0, 0, 8'h0, 32'h0);
    step(1, 1, 1, 0, 8'h05, 32'h0000DEAD, 0, 0, 0, 8'h0, 32'h0);
    step(0, 1, 0, 0, 8'h05, 32'h0, 0, 0, 0, 8'h0, 32'h0);
    idle(0);

    // Single read
    step(0, 1, 0, 0, 8'h10, 32'h0, 0, 0, 0, 8'h0, 32'h0);
    idle(0);

    // Fairness
    idle(1);
    gseq.delete();
    repeat (4) step(0, 1, 0, 0, 8'h01, 32'h0, 1, 0, 0, 8'h02, 32'h0);
    check_seq("fair", '{0, 1, 0, 1});

    // Burst cap
    idle(1);
    gseq.delete();
    k = 0;
    done0 = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, (i >= 1) && !done0, 0, 0, 8'h40, 32'h0,
           1, 0, 1, 8'h30 + 8'(k), 32'h0);
      if (last_g == 0) done0 = 1;
      if (last_g == 1) k++;
    end
    check_seq("burst", '{1, 1, 1, 1, 0, 1});

    // Read after write, consecutive grants
    idle(0);
    step(0, 1, 1, 0, 8'h20, 32'hCAFEF00D, 0, 0, 0, 8'h0, 32'h0);
    step(0, 1, 0, 0, 8'h20, 32'h0, 0, 0, 0, 8'h0, 32'h0);
    idle(0);

    // Reset mid-burst
    gseq.delete();
    step(0, 0, 0, 0, 8'h0, 32'h0, 1, 0, 1, 8'h50, 32'h0);
    step(1, 1, 0, 0, 8'h60, 32'h0, 1, 0, 1, 8'h51, 32'h0);
    step(0, 1, 0, 0, 8'h60, 32'h0, 1, 0, 1, 8'h51, 32'h0);
    check_seq("rst_burst", '{1, -1, 0});
    idle(0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_rq[p]) begin
          if ($urandom_range(2) != 0) begin
            p_rq[p] = 1;
            p_we[p] = 1'($urandom_range(1));
            p_a[p]  = 8'($urandom_range(15));
            p_d[p]  = $urandom;
          end
        end else if ($urandom_range(15) == 0) begin
          p_rq[p] = 0;
        end
        p_lk[p] = ($urandom_range(3) != 0);
      end
      step($urandom_range(63) == 0,
           p_rq[0], p_we[0], p_lk[0], p_a[0], p_d[0],
           p_rq[1], p_we[1], p_lk[1], p_a[1], p_d[1]);
      if (last_g >= 0) p_rq[last_g] = 0;
    end

    idle(0);
    idle(0);
    chk("q0_drained", 32'(q[0].size()), 32'd0);
    chk("q1_drained", 32'(q[1].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
